// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: RV32I load/store width codes,
// FSM state encoding and byte-lane helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Access size in bytes; only the low two func3 bits encode width.
  function automatic logic [2:0] access_bytes(input logic [2:0] f3);
    logic [2:0] nb;
    case (f3[1:0])
      2'b00:   nb = 3'd1;
      2'b01:   nb = 3'd2;
      2'b10:   nb = 3'd4;
      default: nb = 3'd4;
    endcase
    return nb;
  endfunction

  function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << lane;
      2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store mask/replication, misalignment and
// func3 legality checks, and load extraction with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  mask,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  output logic        load_f3_ok,
  output logic        store_f3_ok,
  output logic [31:0] load_val
);

  logic [2:0]  nb_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection, replication and legality decode.
  always_comb begin
    nb_s      = access_bytes(func3);
    mask      = byte_mask(func3, lane);
    misalign  = |(lane & 2'(nb_s - 3'd1));
    byte_s    = rword[{lane, 3'b000} +: 8];
    half_s    = lane[1] ? rword[31:16] : rword[15:0];

    case (func3[1:0])
      2'b00:   wdata_rep = {4{wdata[7:0]}};
      2'b01:   wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase

    case (func3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: load_f3_ok = 1'b1;
      default:                        load_f3_ok = 1'b0;
    endcase

    case (func3)
      F3_B, F3_H, F3_W: store_f3_ok = 1'b1;
      default:          store_f3_ok = 1'b0;
    endcase

    case (func3)
      F3_B:    load_val = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_val = {24'd0, byte_s};
      F3_H:    load_val = {{16{half_s[15]}}, half_s};
      F3_HU:   load_val = {16'd0, half_s};
      default: load_val = rword;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures a load/store pulse, waits LATENCY cycles,
// then performs the access on an internal word RAM and reports completion.
module mem_responder
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  func3,
  output logic [31:0] rdata,
  output logic        mem_rvalid,
  output logic        mem_finish,
  output logic        mem_err,
  output logic        busy
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]  CNT_INIT = (LATENCY > 0) ? CW'(LATENCY - 1) : {CW{1'b0}};
  localparam logic [31:0]    SPAN     = 32'(DEPTH * 4);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          cap_rd;
  logic          cap_wr;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_wdata;
  logic [2:0]    cap_f3;

  logic          acc_rd_s;
  logic          acc_wr_s;
  logic [31:0]   acc_addr_s;
  logic [31:0]   acc_wdata_s;
  logic [2:0]    acc_f3_s;
  logic [31:0]   offset_s;
  logic [AW-1:0] widx_s;
  logic [31:0]   rword_s;
  logic          acc_err_s;
  logic          enter_resp_s;
  logic          load_ok_s;
  logic          ram_we_s;

  logic [3:0]    mask_s;
  logic [31:0]   wdata_rep_s;
  logic          misalign_s;
  logic          load_f3_ok_s;
  logic          store_f3_ok_s;
  logic [31:0]   load_val_s;

  logic [31:0]   ram [DEPTH];

  // With LATENCY=0 the access happens on the capture edge, so the live
  // request is used in IDLE and the captured copy everywhere else.
  always_comb begin
    if (state == IDLE) begin
      acc_rd_s    = mem_read;
      acc_wr_s    = mem_write;
      acc_addr_s  = addr;
      acc_wdata_s = wdata;
      acc_f3_s    = func3;
    end else begin
      acc_rd_s    = cap_rd;
      acc_wr_s    = cap_wr;
      acc_addr_s  = cap_addr;
      acc_wdata_s = cap_wdata;
      acc_f3_s    = cap_f3;
    end
  end

  // Addresses below BASE wrap to a large offset and fail the range test.
  assign offset_s = acc_addr_s - BASE;
  assign widx_s   = offset_s[AW+1:2];
  assign rword_s  = ram[widx_s];

  mem_lane_align u_align (
    .func3       (acc_f3_s),
    .lane        (acc_addr_s[1:0]),
    .wdata       (acc_wdata_s),
    .rword       (rword_s),
    .mask        (mask_s),
    .wdata_rep   (wdata_rep_s),
    .misalign    (misalign_s),
    .load_f3_ok  (load_f3_ok_s),
    .store_f3_ok (store_f3_ok_s),
    .load_val    (load_val_s)
  );

  assign acc_err_s    = (acc_rd_s && acc_wr_s)
                     || (acc_rd_s && !load_f3_ok_s)
                     || (acc_wr_s && !store_f3_ok_s)
                     || misalign_s
                     || !(offset_s < SPAN);
  assign enter_resp_s = ((state == IDLE) && (mem_read || mem_write) && (LATENCY == 0))
                     || ((state == WAIT) && (cnt == {CW{1'b0}}));
  assign load_ok_s    = acc_rd_s && !acc_err_s;
  assign ram_we_s     = enter_resp_s && acc_wr_s && !acc_err_s;

  // Byte-lane RAM write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_s[i]) begin
          ram[widx_s][8*i +: 8] <= wdata_rep_s[8*i +: 8];
        end
      end
    end
  end

  // Request FSM, latency counter, capture registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= {CW{1'b0}};
      cap_rd     <= 1'b0;
      cap_wr     <= 1'b0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
      cap_f3     <= 3'd0;
      rdata      <= 32'd0;
      mem_rvalid <= 1'b0;
      mem_finish <= 1'b0;
      mem_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mem_finish <= enter_resp_s;
      mem_err    <= enter_resp_s && acc_err_s;
      mem_rvalid <= enter_resp_s && load_ok_s;
      if (enter_resp_s && load_ok_s) begin
        rdata <= load_val_s;
      end
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            cap_rd    <= mem_read;
            cap_wr    <= mem_write;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            cap_f3    <= func3;
            busy      <= 1'b1;
            cnt       <= CNT_INIT;
            state     <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == {CW{1'b0}}) begin
            state <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed protocol scenarios plus
// randomized traffic against a byte-addressed reference memory.
module tb_mem_responder;
  import mem_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic        err;
    logic [31:0] exp;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        mem_read, mem_write, mem_rvalid, mem_finish, mem_err, busy;
  logic [31:0] addr, wdata, rdata;
  logic [2:0]  func3;

  logic        z_read, z_write, z_rvalid, z_finish, z_err, z_busy;
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic [2:0]  z_f3;

  mem_responder #(.BASE(BASE), .DEPTH(1024), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .func3(func3), .rdata(rdata),
    .mem_rvalid(mem_rvalid), .mem_finish(mem_finish), .mem_err(mem_err), .busy(busy)
  );

  mem_responder #(.BASE(BASE), .DEPTH(1024), .LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_read(z_read), .mem_write(z_write),
    .addr(z_addr), .wdata(z_wdata), .func3(z_f3), .rdata(z_rdata),
    .mem_rvalid(z_rvalid), .mem_finish(z_finish), .mem_err(z_err), .busy(z_busy)
  );

  int errors = 0;
  int checks = 0;

  // observations from the last request
  int          o_fin_cycle, o_fin_count, o_stray;
  logic        o_err, o_rv;
  logic [31:0] o_rdata;
  logic [6:0]  o_busy;

  // reference model: byte-addressed memory and last good load value
  logic [7:0]  m_mem [4096];
  logic [31:0] m_rdata;
  logic        e_err, e_rv;

  function automatic op_t mk(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [2:0] f3,
                             input logic err, input logic [31:0] exp);
    op_t o;
    o.rd = rd; o.wr = wr; o.a = a; o.wd = wd; o.f3 = f3; o.err = err; o.exp = exp;
    return o;
  endfunction

  task automatic model_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          output logic e, output logic rv);
    int          size;
    logic [31:0] off;
    logic [31:0] val;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = a - BASE;
    e    = 1'b0;
    if (rd && wr) e = 1'b1;
    else if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) e = 1'b1;
    else if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) e = 1'b1;
    if (off >= 32'd4096) e = 1'b1;
    if ((a % 32'(size)) != 32'd0) e = 1'b1;
    rv = rd && !e;
    if (wr && !e) begin
      for (int i = 0; i < size; i++) m_mem[int'(off) + i] = wd[8*i +: 8];
    end
    if (rv) begin
      val = 32'd0;
      for (int i = 0; i < size; i++) val[8*i +: 8] = m_mem[int'(off) + i];
      if (!f3[2] && size == 1) val = {{24{val[7]}}, val[7:0]};
      if (!f3[2] && size == 2) val = {{16{val[15]}}, val[15:0]};
      m_rdata = val;
    end
  endtask

  // Issue one request pulse and watch the following six cycles.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3, input logic extra);
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd; func3 = f3;
    o_fin_cycle = 0; o_fin_count = 0; o_stray = 0;
    o_err = 1'b0; o_rv = 1'b0; o_rdata = 32'd0; o_busy = 7'd0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      o_busy[k] = busy;
      if (mem_finish) begin
        o_fin_count++;
        if (o_fin_cycle == 0) begin
          o_fin_cycle = k; o_err = mem_err; o_rv = mem_rvalid; o_rdata = rdata;
        end
      end else if (mem_rvalid || mem_err) begin
        o_stray++;
      end
      mem_read = (k == 1) ? extra : 1'b0;
      mem_write = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; addr = 32'd0; wdata = 32'd0; func3 = 3'd0;
    z_read = 1'b0; z_write = 1'b0; z_addr = 32'd0; z_wdata = 32'd0; z_f3 = 3'd0;
    m_rdata = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rdata, mem_rvalid, mem_finish, mem_err, busy} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdata=%h rv=%b fin=%b err=%b busy=%b, want all 0",
               rdata, mem_rvalid, mem_finish, mem_err, busy);
    end
    checks++;
    if ({z_rdata, z_rvalid, z_finish, z_err, z_busy} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs_lat0: got rdata=%h busy=%b, want 0", z_rdata, z_busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic run_directed(input string nm, input op_t ops[$]);
    foreach (ops[i]) begin
      do_req(ops[i].rd, ops[i].wr, ops[i].a, ops[i].wd, ops[i].f3, 1'b0);
      model_op(ops[i].rd, ops[i].wr, ops[i].a, ops[i].wd, ops[i].f3, e_err, e_rv);
      checks++;
      if (o_fin_cycle != 3 || o_fin_count != 1 || o_stray != 0) begin
        errors++;
        $display("FAIL %s[%0d] finish: got cycle=%0d count=%0d stray=%0d, want 3/1/0",
                 nm, i, o_fin_cycle, o_fin_count, o_stray);
      end
      checks++;
      if (o_busy !== 7'b0001110) begin
        errors++;
        $display("FAIL %s[%0d] busy: got %b want 0001110", nm, i, o_busy);
      end
      checks++;
      if (o_err !== ops[i].err) begin
        errors++;
        $display("FAIL %s[%0d] err: got %b want %b", nm, i, o_err, ops[i].err);
      end
      checks++;
      if (o_rv !== (ops[i].rd && !ops[i].err)) begin
        errors++;
        $display("FAIL %s[%0d] rvalid: got %b want %b", nm, i, o_rv, ops[i].rd && !ops[i].err);
      end
      checks++;
      if (o_rdata !== ops[i].exp) begin
        errors++;
        $display("FAIL %s[%0d] rdata: got %h want %h", nm, i, o_rdata, ops[i].exp);
      end
    end
  endtask

  task automatic test_store_load();
    op_t ops[$];
    ops.push_back(mk(1'b0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, F3_W, 1'b0, 32'h0000_0000));
    ops.push_back(mk(1'b1, 1'b0, BASE + 32'h10, 32'h0,         F3_W, 1'b0, 32'hDEAD_BEEF));
    run_directed("store_load", ops);
  endtask

  task automatic test_byte_ops();
    op_t ops[$];
    ops.push_back(mk(1'b0, 1'b1, BASE + 32'h11, 32'h0000_00A5, F3_B,  1'b0, 32'hDEAD_BEEF));
    ops.push_back(mk(1'b1, 1'b0, BASE + 32'h10, 32'h0,         F3_W,  1'b0, 32'hDEAD_A5EF));
    ops.push_back(mk(1'b1, 1'b0, BASE + 32'h11, 32'h0,         F3_B,  1'b0, 32'hFFFF_FFA5));
    ops.push_back(mk(1'b1, 1'b0, BASE + 32'h11, 32'h0,         F3_BU, 1'b0, 32'h0000_00A5));
    ops.push_back(mk(1'b1, 1'b0, BASE + 32'h12, 32'h0,         F3_H,  1'b0, 32'hFFFF_DEAD));
    ops.push_back(mk(1'b0, 1'b1, BASE + 32'h16, 32'h0000_8001, F3_H,  1'b0, 32'hFFFF_DEAD));
    ops.push_back(mk(1'b1, 1'b0, BASE + 32'h16, 32'h0,         F3_HU, 1'b0, 32'h0000_8001));
    run_directed("byte_ops", ops);
  endtask

  task automatic test_errors();
    op_t ops[$];
    ops.push_back(mk(1'b1, 1'b0, BASE + 32'h13,  32'h0,         F3_H,   1'b1, 32'h0000_8001));
    ops.push_back(mk(1'b0, 1'b1, BASE + 32'h12,  32'h1122_3344, F3_W,   1'b1, 32'h0000_8001));
    ops.push_back(mk(1'b1, 1'b0, BASE + 32'h10,  32'h0,         F3_W,   1'b0, 32'hDEAD_A5EF));
    ops.push_back(mk(1'b1, 1'b0, 32'h7FFF_FFFC,  32'h0,         F3_W,   1'b1, 32'hDEAD_A5EF));
    ops.push_back(mk(1'b1, 1'b0, 32'h8000_1000,  32'h0,         F3_W,   1'b1, 32'hDEAD_A5EF));
    ops.push_back(mk(1'b1, 1'b1, BASE + 32'h10,  32'h0,         F3_W,   1'b1, 32'hDEAD_A5EF));
    ops.push_back(mk(1'b1, 1'b0, BASE + 32'h10,  32'h0,         3'b011, 1'b1, 32'hDEAD_A5EF));
    ops.push_back(mk(1'b0, 1'b1, BASE + 32'h10,  32'h5555_5555, 3'b100, 1'b1, 32'hDEAD_A5EF));
    ops.push_back(mk(1'b1, 1'b0, BASE + 32'h10,  32'h0,         F3_W,   1'b0, 32'hDEAD_A5EF));
    ops.push_back(mk(1'b0, 1'b1, BASE + 32'hFFC, 32'h0BAD_F00D, F3_W,   1'b0, 32'hDEAD_A5EF));
    ops.push_back(mk(1'b1, 1'b0, BASE + 32'hFFC, 32'h0,         F3_W,   1'b0, 32'h0BAD_F00D));
    run_directed("errors", ops);
  endtask

  task automatic test_busy_ignore();
    do_req(1'b1, 1'b0, BASE + 32'h10, 32'h0, F3_W, 1'b1);
    model_op(1'b1, 1'b0, BASE + 32'h10, 32'h0, F3_W, e_err, e_rv);
    checks++;
    if (o_fin_cycle != 3 || o_fin_count != 1 || o_stray != 0) begin
      errors++;
      $display("FAIL busy_ignore finish: got cycle=%0d count=%0d stray=%0d, want 3/1/0",
               o_fin_cycle, o_fin_count, o_stray);
    end
    checks++;
    if (o_rdata !== 32'hDEAD_A5EF || o_rv !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignore data: got %h rv=%b want DEADA5EF rv=1", o_rdata, o_rv);
    end
  endtask

  task automatic test_reset_midflight();
    int fin;
    do_req(1'b0, 1'b1, BASE + 32'h20, 32'hCAFE_F00D, F3_W, 1'b0);
    model_op(1'b0, 1'b1, BASE + 32'h20, 32'hCAFE_F00D, F3_W, e_err, e_rv);
    checks++;
    if (o_err !== 1'b0 || o_fin_cycle != 3) begin
      errors++;
      $display("FAIL midreset_setup: got err=%b cycle=%0d want 0/3", o_err, o_fin_cycle);
    end
    @(negedge clk);
    mem_write = 1'b1; addr = BASE + 32'h20; wdata = 32'h1234_5678; func3 = F3_W;
    @(negedge clk);
    mem_write = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rdata, mem_rvalid, mem_finish, mem_err, busy} !== 36'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdata=%h busy=%b, want 0", rdata, busy);
    end
    fin = 0;
    repeat (3) begin @(negedge clk); if (mem_finish) fin++; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (mem_finish) fin++; end
    checks++;
    if (fin != 0) begin
      errors++;
      $display("FAIL midreset_nofinish: got %0d finishes want 0", fin);
    end
    m_rdata = 32'd0;
    do_req(1'b1, 1'b0, BASE + 32'h20, 32'h0, F3_W, 1'b0);
    model_op(1'b1, 1'b0, BASE + 32'h20, 32'h0, F3_W, e_err, e_rv);
    checks++;
    if (o_rdata !== 32'hCAFE_F00D || o_err !== 1'b0 || o_fin_cycle != 3) begin
      errors++;
      $display("FAIL midreset_readback: got %h err=%b cycle=%0d want CAFEF00D 0 3",
               o_rdata, o_err, o_fin_cycle);
    end
  endtask

  task automatic test_random();
    logic        rd, wr;
    logic [31:0] a, wd;
    logic [2:0]  f3;
    int          sel;
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      do_req(1'b0, 1'b1, BASE + 32'(4 * w), wd, F3_W, 1'b0);
      model_op(1'b0, 1'b1, BASE + 32'(4 * w), wd, F3_W, e_err, e_rv);
      checks++;
      if (o_err !== 1'b0 || o_fin_cycle != 3 || o_fin_count != 1) begin
        errors++;
        $display("FAIL rand_init[%0d]: got err=%b cycle=%0d count=%0d", w, o_err, o_fin_cycle, o_fin_count);
      end
    end
    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 9));
      rd = (sel == 0) || (sel >= 5);
      wr = (sel <= 4);
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
      else if (sel == 1) a = BASE + 32'h1000 + 32'($urandom_range(0, 15));
      else               a = BASE + 32'($urandom_range(0, 63));
      wd = $urandom;
      f3 = 3'($urandom_range(0, 7));
      do_req(rd, wr, a, wd, f3, 1'b0);
      model_op(rd, wr, a, wd, f3, e_err, e_rv);
      checks++;
      if (o_fin_cycle != 3 || o_fin_count != 1 || o_stray != 0 || o_busy !== 7'b0001110) begin
        errors++;
        $display("FAIL rand[%0d] timing: got cycle=%0d count=%0d stray=%0d busy=%b", n,
                 o_fin_cycle, o_fin_count, o_stray, o_busy);
      end
      checks++;
      if (o_err !== e_err || o_rv !== e_rv) begin
        errors++;
        $display("FAIL rand[%0d] status rd=%b wr=%b a=%h f3=%0d: got err=%b rv=%b want err=%b rv=%b",
                 n, rd, wr, a, f3, o_err, o_rv, e_err, e_rv);
      end
      checks++;
      if (o_rdata !== m_rdata) begin
        errors++;
        $display("FAIL rand[%0d] rdata a=%h f3=%0d: got %h want %h", n, a, f3, o_rdata, m_rdata);
      end
    end
  endtask

  task automatic test_latency0();
    op_t ops[$];
    ops.push_back(mk(1'b0, 1'b1, BASE + 32'h40, 32'hA1B2_C3D4, F3_W,  1'b0, 32'h0000_0000));
    ops.push_back(mk(1'b1, 1'b0, BASE + 32'h41, 32'h0,         F3_B,  1'b0, 32'hFFFF_FFC3));
    ops.push_back(mk(1'b1, 1'b0, BASE + 32'h42, 32'h0,         F3_HU, 1'b0, 32'h0000_A1B2));
    ops.push_back(mk(1'b1, 1'b0, BASE + 32'h43, 32'h0,         F3_H,  1'b1, 32'h0000_A1B2));
    foreach (ops[i]) begin
      @(negedge clk);
      z_read = ops[i].rd; z_write = ops[i].wr; z_addr = ops[i].a;
      z_wdata = ops[i].wd; z_f3 = ops[i].f3;
      @(negedge clk);
      z_read = 1'b0; z_write = 1'b0;
      checks++;
      if (z_finish !== 1'b1 || z_busy !== 1'b1 || z_err !== ops[i].err
          || z_rvalid !== (ops[i].rd && !ops[i].err)) begin
        errors++;
        $display("FAIL lat0[%0d] response: got fin=%b busy=%b err=%b rv=%b", i,
                 z_finish, z_busy, z_err, z_rvalid);
      end
      checks++;
      if (z_rdata !== ops[i].exp) begin
        errors++;
        $display("FAIL lat0[%0d] rdata: got %h want %h", i, z_rdata, ops[i].exp);
      end
      @(negedge clk);
      checks++;
      if (z_finish !== 1'b0 || z_busy !== 1'b0) begin
        errors++;
        $display("FAIL lat0[%0d] release: got fin=%b busy=%b want 0 0", i, z_finish, z_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_ops();
    test_errors();
    test_busy_ignore();
    test_reset_midflight();
    test_latency0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle core's load/store request protocol.
- Accepts a single-cycle mem_read or mem_write pulse with address, write data and func3.
- Performs the access on an internal word-organised data RAM after a configurable latency, then returns mem_finish, and mem_rvalid with aligned, sign- or zero-extended rdata for loads.
- Sits between the decode/execute stages and data memory, and serves as the simulation data memory.

Parameters:
- BASE, 32'h8000_0000, byte address of word 0.
- DEPTH, 1024, number of 32-bit words; power of two.
- LATENCY, 2, extra wait cycles between request capture and response; 0 is legal.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  single-cycle load request pulse.
- mem_write  in  1  single-cycle store request pulse.
- addr  in  32  byte address, sampled with the request.
- wdata  in  32  store data, low bytes significant, sampled with the request.
- func3  in  3  RV32I load/store width and sign, sampled with the request.
- rdata  out  32  load result, valid when mem_rvalid=1, held until the next completed load.
- mem_rvalid  out  1  one-cycle pulse, load data valid, always coincident with mem_finish.
- mem_finish  out  1  one-cycle pulse, request complete (load, store or error).
- mem_err  out  1  one-cycle pulse with mem_finish when the request was rejected.
- busy  out  1  high from the cycle after capture through the response cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE; rdata, mem_rvalid, mem_finish, mem_err and busy all go to 0; the latency counter clears.
  - RAM contents are not reset.
  - An in-flight store is discarded and never committed.
- States:
  - IDLE: a request pulse captures addr, wdata, func3 and the kind (read/write). Go to WAIT, or directly to RESP when LATENCY=0; the counter loads LATENCY-1.
  - WAIT: decrement the counter; at 0 go to RESP.
  - RESP: mem_finish=1 for exactly one cycle (plus mem_rvalid for a successful load, or mem_err on rejection); then return to IDLE.
- Timing: a request high in cycle T gives mem_finish in cycle T+1+LATENCY. The next request is accepted no earlier than cycle T+2+LATENCY.
- Requests outside IDLE are ignored: no capture, no response, no error.
- mem_read and mem_write high together: reject with mem_err, no RAM access.
- Validity checks (any failure means reject, no RAM write, rdata unchanged, mem_rvalid=0):
  - Loads: func3 must be 000 LB, 001 LH, 010 LW, 100 LBU or 101 LHU.
  - Stores: func3 must be 000 SB, 001 SH or 010 SW.
  - Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
  - Range: addr-BASE must be below DEPTH*4, computed in 32-bit unsigned arithmetic so addresses below BASE wrap high and are rejected.
- Stores:
  - Byte mask: SB = 1 lane at addr[1:0]; SH = lanes {addr[1],0},{addr[1],1}; SW = all lanes.
  - Write data is replicated to the lanes (SB: wdata[7:0] to every lane; SH: wdata[15:0] to both halves).
  - The write commits on the clock edge entering RESP, so a load issued after mem_finish sees it.
- Loads:
  - The word is read in the RESP-entry cycle.
  - Extraction: LB/LBU take byte lane addr[1:0]; LH/LHU take halfword addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - rdata updates only on a successful load.

Decomposition:
- Package mem_pkg: FUNC3 load/store constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum {IDLE, WAIT, RESP}, and helpers for byte-mask width.
- Sub-module mem_lane_align (combinational):
  - func3 + addr[1:0] + wdata produce the byte mask, replicated write data and a misalign flag.
  - func3 + addr[1:0] + RAM word produce the extended load value.
- The FSM, counter and RAM stay in mem_responder.

Test Plan (BASE=0x8000_0000, DEPTH=1024, LATENCY=2 unless noted):
- SW addr 0x8000_0010 wdata 0xDEADBEEF in cycle 0 -> mem_finish in cycle 3, mem_rvalid=0, busy 1-3. Then LW of the same address -> rdata 0xDEADBEEF with mem_rvalid=mem_finish=1 three cycles after the request.
- SB 0x8000_0011 wdata 0x0000_00A5, then:
  - LW 0x8000_0010 -> 0xDEADA5EF.
  - LB 0x8000_0011 -> 0xFFFF_FFA5.
  - LBU -> 0x0000_00A5.
  - LH 0x8000_0012 -> 0xFFFF_DEAD.
- LH 0x8000_0013 -> mem_finish+mem_err in cycle 3, mem_rvalid=0, rdata unchanged. SW 0x8000_0012 -> mem_err, and a following LW 0x8000_0010 still returns 0xDEADA5EF.
- LW 0x7FFF_FFFC and LW 0x8000_1000 -> mem_err. mem_read+mem_write in the same cycle -> mem_err.
- mem_read pulse in cycle 1 while busy -> ignored; exactly one mem_finish, in cycle 3.
- SW 0x8000_0020 wdata 0x1234_5678 with rst_n=0 during WAIT -> outputs 0 immediately, no mem_finish; after reset, LW 0x8000_0020 returns the prior contents. With LATENCY=0, a request in cycle 0 -> mem_finish in cycle 1.
